// File: rtl/cpu_host_if.sv
// Host-side helper for the CPU: debounces a push-button into `trigger` and
// streams every new `a0` value through a small show-ahead FIFO.
module cpu_host_if #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_in,
    input  logic [DATA_WIDTH-1:0]         a0,
    output logic                          trigger,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

    logic                  s1;
    logic                  s2;
    logic [DBW-1:0]        db_cnt;
    db_state_e             db_state;

    logic [DATA_WIDTH-1:0] a0_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr_nxt;
    logic [PW-1:0]         rd_ptr_nxt;

    logic                  push_req;
    logic                  full;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;

    // Debouncer is pending whenever the synchronised level disagrees with trigger.
    always_comb begin
        db_state = (s2 != trigger) ? ST_PENDING : ST_STABLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            db_cnt  <= '0;
            trigger <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
            case (db_state)
                ST_PENDING: begin
                    if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                        trigger <= s2;
                        db_cnt  <= '0;
                    end else begin
                        db_cnt  <= db_cnt + DBW'(1);
                    end
                end
                default: db_cnt <= '0;
            endcase
        end
    end

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    always_comb begin
        push_req   = (a0 != a0_q);
        full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        pop        = out_valid && out_ready;
        wr_en      = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        wr_ptr_nxt = wr_ptr + PW'(wr_en);
        rd_ptr_nxt = rd_ptr + PW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a0_q       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push_req) begin
                a0_q <= a0;
            end
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            fifo_count <= wr_ptr_nxt - rd_ptr_nxt;
            out_valid  <= (wr_ptr_nxt != rd_ptr_nxt);
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= a0;
        end
    end

    assign out_data = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule
